// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int UART_DATA_WIDTH           = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and serialises each as start, LSB-first data, stop.
//  state | meaning
//  IDLE  | line high, pop the FIFO head as soon as it is non-empty
//  START | drive start bit (0) for one bit period
//  DATA  | drive shift_q[0] per bit period, shifting right between bits
//  STOP  | drive stop bit (1); done tick in its last cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state_q, state_d;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign shift_nxt = shift_q >> 1;
    // Gated with reset_n so no pop can leak out while the block is held in reset.
    assign fifo_rd   = reset_n && (state_q == IDLE) && !fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_rd) state_d = START;
            START:   if (baud_done) state_d = DATA;
            DATA:    if (baud_done && (bit_idx == IDX_LAST)) state_d = STOP;
            STOP:    if (baud_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    tx           <= 1'b1;
                    tx_done_tick <= 1'b0;
                    if (fifo_rd) begin
                        shift_q  <= fifo_r_data;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_q[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift_q  <= shift_nxt;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    // Registered tick: armed one cycle early so it lands in the final stop cycle.
                    tx_done_tick <= (baud_cnt == BAUD_PRE);
                    if (baud_done) begin
                        baud_cnt     <= '0;
                        tx_busy      <= 1'b0;
                        tx_done_tick <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset_n;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    int n_checks;
    int n_fail;
    int cyc;
    int last_wait;
    int p1, p2, p3;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Waits for a pop, then checks every cycle of the following frame against exp_byte.
    task automatic run_frame(input string tag, input logic [7:0] exp_byte,
                             input logic nxt_empty, input logic [7:0] nxt_data,
                             output int pop_cyc);
        int n;
        logic [9:0] frame;
        logic [7:0] dec;
        n = 0;
        dec = 8'h00;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd && n < 200);
        check_val({tag, "_pop"}, fifo_rd, 1);
        check_val({tag, "_idle_tx"}, tx, 1);
        pop_cyc   = cyc;
        last_wait = n;
        @(posedge clk);
        #1;
        fifo_empty  = nxt_empty;
        fifo_r_data = nxt_data;
        frame = {1'b1, exp_byte, 1'b0};
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_val($sformatf("%s_tx_c%0d", tag, k), tx, frame[(k-1)/CPB]);
            check_val($sformatf("%s_busy_c%0d", tag, k), tx_busy, 1);
            check_val($sformatf("%s_rd_c%0d", tag, k), fifo_rd, 0);
            check_val($sformatf("%s_done_c%0d", tag, k), tx_done_tick, (k == FRAME) ? 1 : 0);
            if (k >= 6 && k <= 34 && ((k - 1) % CPB) == 1) dec[(k-5)/CPB] = tx;
        end
        check_val({tag, "_byte"}, dec, exp_byte);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        fifo_empty  = 1'b1;
        fifo_r_data = 8'h00;

        // 1: reset, then idle with an empty FIFO
        @(negedge clk);
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", tx_busy, 0);
        check_val("rst_rd", fifo_rd, 0);
        check_val("rst_done", tx_done_tick, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle_tx", tx, 1);
            check_val("idle_rd", fifo_rd, 0);
            check_val("idle_busy", tx_busy, 0);
            check_val("idle_done", tx_done_tick, 0);
        end

        // 2: single word 0xA5
        @(posedge clk);
        #1;
        fifo_r_data = 8'hA5;
        fifo_empty  = 1'b0;
        run_frame("t2", 8'hA5, 1'b1, 8'h00, p1);
        check_val("t2_pop_latency", last_wait, 1);
        @(negedge clk);
        check_val("t2_after_rd", fifo_rd, 0);
        check_val("t2_after_busy", tx_busy, 0);

        // 3: back-to-back 0x05, 0x08, 0x02
        @(posedge clk);
        #1;
        fifo_r_data = 8'h05;
        fifo_empty  = 1'b0;
        run_frame("t3a", 8'h05, 1'b0, 8'h08, p1);
        run_frame("t3b", 8'h08, 1'b0, 8'h02, p2);
        check_val("t3b_gap_wait", last_wait, 1);
        run_frame("t3c", 8'h02, 1'b1, 8'h00, p3);
        check_val("t3_spacing_ab", p2 - p1, FRAME + 1);
        check_val("t3_spacing_bc", p3 - p2, FRAME + 1);

        // 4 + 6: head changes to 0xFF mid-frame, then 0xFF and 0x00 frames follow
        @(posedge clk);
        #1;
        fifo_r_data = 8'h3C;
        fifo_empty  = 1'b0;
        run_frame("t4", 8'h3C, 1'b0, 8'hFF, p1);
        run_frame("t6ff", 8'hFF, 1'b0, 8'h00, p2);
        run_frame("t6zero", 8'h00, 1'b1, 8'h00, p3);
        check_val("t6_spacing_ff", p2 - p1, FRAME + 1);
        check_val("t6_spacing_00", p3 - p2, FRAME + 1);

        // 5: reset during DATA bit 3 of 0x96 (bit3 = 0)
        @(posedge clk);
        #1;
        fifo_r_data = 8'h96;
        fifo_empty  = 1'b0;
        last_wait = 0;
        do begin
            @(negedge clk);
            last_wait++;
        end while (!fifo_rd && last_wait < 200);
        check_val("t5_pop", fifo_rd, 1);
        @(posedge clk);
        #1;
        fifo_r_data = 8'h81;
        repeat (18) @(negedge clk);
        check_val("t5_pre_tx", tx, 0);
        check_val("t5_pre_busy", tx_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("t5_async_tx", tx, 1);
        check_val("t5_async_busy", tx_busy, 0);
        check_val("t5_async_rd", fifo_rd, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_frame("t5", 8'h81, 1'b1, 8'h00, p1);
        check_val("t5_first_cycle_pop", last_wait, 1);

        repeat (3) @(negedge clk);
        check_val("end_tx", tx, 1);
        check_val("end_busy", tx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
